// File: rtl/video_pkg.sv
// Shared raster timing constants, pixel constants and the sync bundle
// passed through the alignment delay line.
package video_pkg;

  localparam int CNT_W   = 9;
  localparam int CNT_LIM = 512;

  localparam int H_DISPLAY_DEF = 256;
  localparam int H_FRONT_DEF   = 7;
  localparam int H_SYNC_DEF    = 23;
  localparam int H_BACK_DEF    = 23;
  localparam int V_DISPLAY_DEF = 240;
  localparam int V_BOTTOM_DEF  = 14;
  localparam int V_SYNC_DEF    = 3;
  localparam int V_TOP_DEF     = 5;

  localparam logic [31:0] RGB_BLANK = 32'hff000000;
  localparam logic [7:0]  ALPHA     = 8'hff;

  typedef logic [CNT_W-1:0] pos_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic logic in_range(pos_t x, pos_t lo, pos_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/video_sync_gen_if.sv
// Beam position out to the pixel source, colour back in,
// aligned pixel and sync out to the video pins.
interface video_sync_gen_if;
  import video_pkg::*;

  pos_t        hpos;
  pos_t        vpos;
  logic        display_on;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [31:0] rgb;
  logic        hsync;
  logic        vsync;

  modport master (
    output hpos, vpos, display_on,
    output line_start, frame_start,
    output rgb, hsync, vsync,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  hpos, vpos, display_on,
    input  line_start, frame_start,
    input  rgb, hsync, vsync,
    output pix_r, pix_g, pix_b
  );

endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// o_tap is one stage short of o_q so a register fed by it lines up.
module video_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_tap,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // shift one stage per clock, clear all stages on reset
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++)
        r_sr[i] <= r_sr[i-1];
    end
  end

  if (DEPTH == 1) begin : g_tap_in
    assign o_tap = i_d;
  end else begin : g_tap_sr
    assign o_tap = r_sr[DEPTH-2];
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_sync_gen.sv
// Raster counters plus output stage that aligns returned colour
// with sync and blanking delayed by the source latency.
module video_sync_gen
  import video_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_BOTTOM  = V_BOTTOM_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_TOP     = V_TOP_DEF,
  parameter int SRC_LAT   = 0,
  parameter bit SYNC_POL  = 1'b1
) (
  input logic         clk,
  input logic         reset,
  video_sync_gen_if.master bus
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  if (H_TOTAL > CNT_LIM || V_TOTAL > CNT_LIM ||
      SRC_LAT < 0 || SRC_LAT > 3) begin : g_bad_params
    $error("video_sync_gen: illegal timing parameters");
  end

  localparam pos_t H_MAX  = pos_t'(H_TOTAL - 1);
  localparam pos_t V_MAX  = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS  = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS  = pos_t'(V_DISPLAY);
  localparam pos_t HS_ON  = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_OFF =
    pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_ON  = pos_t'(V_DISPLAY + V_BOTTOM);
  localparam pos_t VS_OFF =
    pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  pos_t        r_hpos;
  pos_t        r_vpos;
  logic [31:0] r_rgb;
  logic        w_de;
  sync_t       w_raw;
  sync_t       w_tap;
  sync_t       w_dly;
  logic        w_unused;

  // beam counters: column every clock, line on column wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (r_hpos == H_MAX) begin
      r_hpos <= '0;
      if (r_vpos == V_MAX)
        r_vpos <= '0;
      else
        r_vpos <= r_vpos + 9'd1;
    end else begin
      r_hpos <= r_hpos + 9'd1;
    end
  end

  assign w_de = (r_hpos < H_VIS) && (r_vpos < V_VIS);

  assign w_raw.hs = in_range(r_hpos, HS_ON, HS_OFF);
  assign w_raw.vs = in_range(r_vpos, VS_ON, VS_OFF);
  assign w_raw.de = w_de;

  video_delay_line #(
    .DEPTH (SRC_LAT + 1),
    .WIDTH ($bits(sync_t))
  ) u_dly (
    .clk     (clk),
    .i_clr_n (reset),
    .i_d     (w_raw),
    .o_tap   (w_tap),
    .o_q     (w_dly)
  );

  // pixel register: take source colour only in the visible window
  always_ff @(posedge clk) begin
    if (!reset)
      r_rgb <= RGB_BLANK;
    else if (w_tap.de)
      r_rgb <= {ALPHA, bus.pix_b, bus.pix_g, bus.pix_r};
    else
      r_rgb <= RGB_BLANK;
  end

  assign w_unused = ^{w_tap.hs, w_tap.vs, w_dly.de};

  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.display_on  = w_de;
  assign bus.line_start  = (r_hpos == '0);
  assign bus.frame_start = (r_hpos == '0) && (r_vpos == '0);
  assign bus.rgb         = r_rgb;
  assign bus.hsync       = w_dly.hs ~^ SYNC_POL;
  assign bus.vsync       = w_dly.vs ~^ SYNC_POL;

endmodule

// File: tb/tb_video_sync_gen.sv
// Three generators (lat0/pol1, lat0/pol0, lat2/pol1) checked against
// a position model, an output scoreboard and a checkpoint table.
module tb_video_sync_gen;

  localparam int HT = 309;
  localparam int VT = 262;
  localparam logic [31:0] BLANK = 32'hff000000;

  typedef struct {
    int h; int v;
    bit de; bit ls; bit fs; bit hs; bit vs;
    logic [31:0] rgb2;
  } vec_t;

  typedef struct packed {
    logic [31:0] rgb; logic hs; logic vs;
  } exp_t;

  typedef struct { int due; int idx; } pend_t;
  typedef struct { int h; int v; } hpos_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  video_sync_gen_if if0();
  video_sync_gen_if if1();
  video_sync_gen_if if2();

  video_sync_gen #(.SRC_LAT(0), .SYNC_POL(1)) u_d0 (
    .clk(clk), .reset(rst_a), .bus(if0));
  video_sync_gen #(.SRC_LAT(0), .SYNC_POL(0)) u_n0 (
    .clk(clk), .reset(rst_a), .bus(if1));
  video_sync_gen #(.SRC_LAT(2), .SYNC_POL(1)) u_d2 (
    .clk(clk), .reset(rst_b), .bus(if2));

  vec_t  tbl[15];
  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  q2[$];
  pend_t pq0[$];
  pend_t pq2[$];
  hpos_t hist[$];
  int    mh[3];
  int    mv[3];
  int    cnt_err[3];
  int    out_err[3];
  int    nchk = 0;
  int    nfail = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit hsr(int h);
    return h >= 263 && h <= 285;
  endfunction

  function automatic bit vsr(int v);
    return v >= 254 && v <= 256;
  endfunction

  function automatic logic [31:0] px(int h, int v);
    if (h < 256 && v < 240)
      return {8'hff, 8'h5a, 8'(v), 8'(h)};
    return BLANK;
  endfunction

  function automatic exp_t mk(int h, int v, bit pol);
    exp_t e;
    e.rgb = px(h, v);
    e.hs  = hsr(h) ~^ pol;
    e.vs  = vsr(v) ~^ pol;
    return e;
  endfunction

  function automatic exp_t mk_blank(bit pol);
    exp_t e;
    e.rgb = BLANK;
    e.hs  = ~pol;
    e.vs  = ~pol;
    return e;
  endfunction

  task automatic fill(int l);
    if (l == 0) begin
      q0.delete(); q0.push_back(mk_blank(1'b1));
    end else if (l == 1) begin
      q1.delete(); q1.push_back(mk_blank(1'b0));
    end else begin
      q2.delete();
      repeat (3) q2.push_back(mk_blank(1'b1));
    end
  endtask

  task automatic adv(int l);
    if (mh[l] == HT - 1) begin
      mh[l] = 0;
      mv[l] = (mv[l] == VT - 1) ? 0 : mv[l] + 1;
    end else begin
      mh[l] = mh[l] + 1;
    end
  endtask

  initial begin
    int    cyc;
    int    period;
    int    lines;
    int    post2;
    bit    rst2_done;
    logic  nowb;
    exp_t  e;

    tbl[0]  = '{0,   0,   1,1,1,0,0, 32'hff5a0000};
    tbl[1]  = '{10,  20,  1,0,0,0,0, 32'hff5a140a};
    tbl[2]  = '{255, 239, 1,0,0,0,0, 32'hff5aefff};
    tbl[3]  = '{256, 239, 0,0,0,0,0, BLANK};
    tbl[4]  = '{262, 0,   0,0,0,0,0, BLANK};
    tbl[5]  = '{263, 0,   0,0,0,1,0, BLANK};
    tbl[6]  = '{285, 5,   0,0,0,1,0, BLANK};
    tbl[7]  = '{286, 5,   0,0,0,0,0, BLANK};
    tbl[8]  = '{300, 20,  0,0,0,0,0, BLANK};
    tbl[9]  = '{0,   240, 0,1,0,0,0, BLANK};
    tbl[10] = '{0,   254, 0,1,0,0,1, BLANK};
    tbl[11] = '{100, 256, 0,0,0,0,1, BLANK};
    tbl[12] = '{0,   257, 0,1,0,0,0, BLANK};
    tbl[13] = '{308, 261, 0,0,0,0,0, BLANK};
    tbl[14] = '{264, 255, 0,0,0,1,1, BLANK};

    rst_a = 1'b0;
    rst_b = 1'b0;
    if0.pix_r = '0; if0.pix_g = '0; if0.pix_b = '0;
    if1.pix_r = '0; if1.pix_g = '0; if1.pix_b = '0;
    if2.pix_r = '0; if2.pix_g = '0; if2.pix_b = '0;
    repeat (5) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int l = 0; l < 3; l++) begin
      mh[l] = 0; mv[l] = 0;
      cnt_err[l] = 0; out_err[l] = 0;
      fill(l);
    end

    check("rst_hpos", 32'(if0.hpos), 0);
    check("rst_vpos", 32'(if0.vpos), 0);
    check("rst_frame_start", 32'(if0.frame_start), 1);
    check("rst_rgb", if0.rgb, BLANK);
    check("rst_vsync", 32'(if0.vsync), 0);
    check("rst_hsync_pol0", 32'(if1.hsync), 1);

    cyc = 0; period = -1; lines = 0;
    post2 = 0; rst2_done = 1'b0;

    while (period < 0 && cyc < 81200) begin
      if (post2 >= 0 && post2 <= 3) begin
        if (post2 == 0) begin
          check("rst2_hpos", 32'(if2.hpos), 0);
          check("rst2_vpos", 32'(if2.vpos), 0);
          check("rst2_frame_start",
                32'(if2.frame_start), 1);
        end
        if (post2 < 3)
          check($sformatf("rst2_blank%0d", post2),
                if2.rgb, BLANK);
        else
          check("rst2_first_pix", if2.rgb, 32'hff5a0000);
        post2++;
      end

      if (if0.hpos !== 9'(mh[0]) || if0.vpos !== 9'(mv[0]))
        cnt_err[0]++;
      if (if1.hpos !== 9'(mh[1]) || if1.vpos !== 9'(mv[1]))
        cnt_err[1]++;
      if (if2.hpos !== 9'(mh[2]) || if2.vpos !== 9'(mv[2]))
        cnt_err[2]++;
      e = q0.pop_front();
      if ({if0.rgb, if0.hsync, if0.vsync} !== e) out_err[0]++;
      e = q1.pop_front();
      if ({if1.rgb, if1.hsync, if1.vsync} !== e) out_err[1]++;
      e = q2.pop_front();
      if ({if2.rgb, if2.hsync, if2.vsync} !== e) out_err[2]++;

      while (pq0.size() > 0 && pq0[0].due == cyc) begin
        pend_t p;
        p = pq0.pop_front();
        check($sformatf("hsync@%0d,%0d", tbl[p.idx].h,
              tbl[p.idx].v), 32'(if0.hsync), 32'(tbl[p.idx].hs));
        check($sformatf("vsync@%0d,%0d", tbl[p.idx].h,
              tbl[p.idx].v), 32'(if0.vsync), 32'(tbl[p.idx].vs));
        check($sformatf("hsync_n@%0d,%0d", tbl[p.idx].h,
              tbl[p.idx].v), 32'(if1.hsync), 32'(!tbl[p.idx].hs));
      end
      while (pq2.size() > 0 && pq2[0].due == cyc) begin
        pend_t p;
        p = pq2.pop_front();
        check($sformatf("rgb_lat2@%0d,%0d", tbl[p.idx].h,
              tbl[p.idx].v), if2.rgb, tbl[p.idx].rgb2);
      end

      for (int i = 0; i < 15; i++) begin
        if (mh[0] == tbl[i].h && mv[0] == tbl[i].v) begin
          check($sformatf("de@%0d,%0d", tbl[i].h, tbl[i].v),
                32'(if0.display_on), 32'(tbl[i].de));
          check($sformatf("ls@%0d,%0d", tbl[i].h, tbl[i].v),
                32'(if0.line_start), 32'(tbl[i].ls));
          check($sformatf("fs@%0d,%0d", tbl[i].h, tbl[i].v),
                32'(if0.frame_start), 32'(tbl[i].fs));
          pq0.push_back('{cyc + 1, i});
        end
        if (mh[2] == tbl[i].h && mv[2] == tbl[i].v)
          pq2.push_back('{cyc + 3, i});
      end

      if (cyc > 0 && if0.frame_start)
        period = cyc;
      else if (if0.line_start)
        lines++;

      if0.pix_r = 8'(mh[0]); if0.pix_g = 8'(mv[0]);
      if0.pix_b = 8'h5a;
      if1.pix_r = 8'(mh[1]); if1.pix_g = 8'(mv[1]);
      if1.pix_b = 8'h5a;
      hist.push_back('{mh[2], mv[2]});
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3) begin
        if2.pix_r = 8'(hist[0].h); if2.pix_g = 8'(hist[0].v);
        if2.pix_b = 8'h5a;
      end else begin
        if2.pix_r = 8'hee; if2.pix_g = 8'hee;
        if2.pix_b = 8'hee;
      end
      q0.push_back(mk(mh[0], mv[0], 1'b1));
      q1.push_back(mk(mh[1], mv[1], 1'b0));
      q2.push_back(mk(mh[2], mv[2], 1'b1));

      if (!rst2_done && mh[2] == 150 && mv[2] == 100) begin
        rst_b = 1'b0;
        rst2_done = 1'b1;
      end
      nowb = rst_b;

      @(posedge clk);
      #1;
      cyc++;
      if (!nowb) begin
        mh[2] = 0; mv[2] = 0;
        fill(2);
        rst_b = 1'b1;
        post2 = 0;
      end else begin
        adv(2);
      end
      adv(0);
      adv(1);
    end

    check("frame_period", period, 80958);
    check("line_count", lines, 262);
    check("counters_lat0", cnt_err[0], 0);
    check("counters_pol0", cnt_err[1], 0);
    check("counters_lat2", cnt_err[2], 0);
    check("outputs_lat0", out_err[0], 0);
    check("outputs_pol0", out_err[1], 0);
    check("outputs_lat2", out_err[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
